aclint_timer: RTL and testbench
===============================

Name: aclint_timer

Overview:
- Parametrised successor to the single-mode core-local interruptor; serves cpu_total harts with machine software interrupts (MSWI), machine timer (MTIMER) and supervisor software interrupts (SSWI).
- Adds a programmable tick prescaler, writable mtime, debug-halt freeze, byte-strobe writes and an error response for unmapped offsets.
- Sits behind the SoC AXI slave adapter; its outputs fan out to the hart interrupt inputs and the shadow mtime bus.

Parameters:
- cpu_total, 4, number of harts (1..32).
- presc_default, 0, reset value of the prescaler divisor-1 field; tick every presc+1 clocks.
- mtimecmp_rst, 64'hFFFFFFFFFFFFFFFF, reset value of every mtimecmp; the all-ones default prevents mtip at reset.

Ports:
- clk  in  1  clock.
- nrst  in  1  reset, asynchronous, active-low.
- i_req_valid  in  1  request strobe.
- o_req_ready  out  1  always 1; a request is accepted in every cycle.
- i_req_addr  in  16  byte offset; bits [2:0] ignored (64-bit aligned).
- i_req_write  in  1  1 = write.
- i_req_wdata  in  64  write data.
- i_req_wstrb  in  8  byte enables.
- o_resp_valid  out  1  response, exactly 1 cycle after accept.
- o_resp_rdata  out  64  read data, registered.
- o_resp_err  out  1  unmapped offset.
- i_dbg_halt  in  1  debug halt indication from the DMI.
- o_mtimer  out  64  current mtime.
- o_msip  out  cpu_total  machine software interrupt per hart.
- o_mtip  out  cpu_total  machine timer interrupt per hart.
- o_ssip  out  cpu_total  supervisor software interrupt per hart.

Behaviour:
- Async reset. All outputs reset to 0, except o_req_ready=1. Internal reset values: mtime=0, msip=0, ssip=0, mtimecmp[h]=mtimecmp_rst, ctrl.en=1, ctrl.halt_en=1, ctrl.presc=presc_default, presc counter=0.
- Register map, offsets within 64 KB:
  - 0x0000+4h: msip[h], bit0 RW; other bits read 0.
  - 0x4000+8h: mtimecmp[h], 64-bit RW.
  - 0xBFF0: CTRL. [0] en, [1] halt_en, [31:16] presc; other bits read 0.
  - 0xBFF8: mtime, 64-bit RW.
  - 0xC000+4h: ssip[h], bit0 RW.
- 32-bit registers pack two per 64-bit word. Lanes [3:0] map to the even hart, lanes [7:4] to hart+1. A register is written only if any strobe in its lane group is set.
- 64-bit registers update byte-wise per wstrb.
- Hart index >= cpu_total within a valid window: read 0, write ignored, err=0.
- Any other offset: resp_err=1, rdata=0, no state change.
- Response timing: accept in cycle N gives o_resp_valid=1 in N+1. rdata reflects register values before any write accepted in cycle N (read-before-write).
- Tick logic:
  - freeze = ~ctrl.en | (ctrl.halt_en & i_dbg_halt).
  - When not frozen, the presc counter increments each clk. When counter==ctrl.presc: tick, counter clears, mtime+1.
  - mtime wraps 2^64-1 -> 0.
  - While frozen, the counter holds its value.
  - A write to CTRL.presc clears the counter.
- Simultaneous events: a mtime write in the same cycle as a tick loads the written bytes; unwritten bytes take the ticked value; the counter clears. A mtimecmp write and a compare in the same cycle: the compare uses old values.
- mtip: o_mtip[h] registered as (mtime >= mtimecmp[h]), unsigned 64-bit, using current register values. It therefore lags a mtime/mtimecmp change by 1 cycle and deasserts 1 cycle after mtimecmp is raised above mtime.
- Async reset mid-transaction: a pending response is dropped (o_resp_valid=0). The first response after reset corresponds to a request accepted after reset release.

Test Plan:
- Reset: nrst low mid-read -> o_resp_valid=0, o_mtip=0, o_mtimer=0; read 0x4000 after release -> 64'hFFFFFFFFFFFFFFFF.
- Prescaler: write CTRL presc=3, en=1 -> o_mtimer increments every 4 clk; after 40 clk it reads 10 (±1).
- Timer interrupt, cpu_total=4: write mtimecmp[2]=100 with presc=0 -> o_mtip[2] rises exactly 1 cycle after mtime reaches 100, other bits stay 0. Writing mtimecmp[2]=all-ones -> o_mtip[2] falls 1 cycle later.
- Packed software interrupts: write 0x0000 wdata=64'h1_00000001 wstrb=8'hF0 -> only o_msip[1]=1. Write 0xC008 wstrb=8'h0F data=1 -> o_ssip[2]=1.
- Halt and wrap: halt_en=1, i_dbg_halt=1 -> mtime frozen 20 clk; i_dbg_halt=0 -> resumes. Write mtime=2^64-2 -> reads 0 two ticks later.
- Errors and edges: read 0x8000 -> resp_err=1, rdata=0. Read 0x4020 (hart 4, cpu_total=4) -> rdata=0, err=0. Write mtime low bytes (wstrb=8'h0F) in a tick cycle -> upper half = ticked value.

Source files
------------

// File: rtl/aclint_timer_if.sv
// Request/response bus between the SoC AXI slave adapter and the ACLINT timer.
// One request per cycle is accepted; the response follows one cycle later.
interface aclint_timer_if;
  logic        i_req_valid;
  logic        o_req_ready;
  logic [15:0] i_req_addr;
  logic        i_req_write;
  logic [63:0] i_req_wdata;
  logic [7:0]  i_req_wstrb;
  logic        o_resp_valid;
  logic [63:0] o_resp_rdata;
  logic        o_resp_err;

  modport master (
    output i_req_valid, i_req_addr, i_req_write, i_req_wdata, i_req_wstrb,
    input  o_req_ready, o_resp_valid, o_resp_rdata, o_resp_err
  );

  modport slave (
    input  i_req_valid, i_req_addr, i_req_write, i_req_wdata, i_req_wstrb,
    output o_req_ready, o_resp_valid, o_resp_rdata, o_resp_err
  );
endinterface

// File: rtl/aclint_timer.sv
// ACLINT core-local interruptor: MSWI, MTIMER and SSWI for cpu_total harts,
// with a tick prescaler, writable mtime, debug-halt freeze and unmapped-offset errors.
module aclint_timer #(
  parameter int          cpu_total     = 4,
  parameter logic [15:0] presc_default = 16'd0,
  parameter logic [63:0] mtimecmp_rst  = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic                 clk,
  input  logic                 nrst,
  aclint_timer_if.slave        bus,
  input  logic                 i_dbg_halt,
  output logic [63:0]          o_mtimer,
  output logic [cpu_total-1:0] o_msip,
  output logic [cpu_total-1:0] o_mtip,
  output logic [cpu_total-1:0] o_ssip
);

  // Byte-lane merge used by every 64-bit register write.
  function automatic logic [63:0] merge_bytes(input logic [63:0] old_val,
                                              input logic [63:0] new_val,
                                              input logic [7:0]  strb);
    logic [63:0] res;
    res = old_val;
    for (int b = 0; b < 8; b++) begin
      if (strb[b]) res[b*8 +: 8] = new_val[b*8 +: 8];
    end
    return res;
  endfunction

  logic [15:0] addr;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        wr;
  logic        lo_wr, hi_wr;

  assign addr  = bus.i_req_addr;
  assign wdata = bus.i_req_wdata;
  assign wstrb = bus.i_req_wstrb;
  assign wr    = bus.i_req_valid & bus.i_req_write;
  assign lo_wr = |wstrb[3:0];
  assign hi_wr = |wstrb[7:4];

  // Windows are sized for the 32-hart maximum; anything outside them is an error.
  logic       sel_msip, sel_cmp, sel_ctrl, sel_mtime, sel_ssip, map_err;
  logic [3:0] pair_idx;
  logic [4:0] cmp_idx;

  assign sel_msip  = (addr[15:7] == 9'h000);
  assign sel_cmp   = (addr[15:8] == 8'h40);
  assign sel_ctrl  = (addr[15:3] == 13'h17FE);
  assign sel_mtime = (addr[15:3] == 13'h17FF);
  assign sel_ssip  = (addr[15:7] == 9'h180);
  assign map_err   = ~(sel_msip | sel_cmp | sel_ctrl | sel_mtime | sel_ssip);
  assign pair_idx  = addr[6:3];
  assign cmp_idx   = addr[7:3];

  logic unused_addr_bits;
  assign unused_addr_bits = &{1'b0, addr[2:0]};

  logic [cpu_total-1:0] msip_q, ssip_q;
  logic [63:0]          mtimecmp_q [cpu_total];
  logic [63:0]          mtime_q;
  logic                 en_q, halt_en_q;
  logic [15:0]          presc_q;
  logic [15:0]          cnt_q;

  logic [31:0] msip_pad, ssip_pad;
  assign msip_pad = 32'(msip_q);
  assign ssip_pad = 32'(ssip_q);

  // Read mux over current register values (read-before-write).
  logic [63:0] rd_data;
  always_comb begin
    rd_data = '0;
    if (sel_msip) begin
      rd_data = {31'b0, msip_pad[{pair_idx, 1'b1}], 31'b0, msip_pad[{pair_idx, 1'b0}]};
    end else if (sel_ssip) begin
      rd_data = {31'b0, ssip_pad[{pair_idx, 1'b1}], 31'b0, ssip_pad[{pair_idx, 1'b0}]};
    end else if (sel_cmp) begin
      for (int h = 0; h < cpu_total; h++) begin
        if (cmp_idx == 5'(h)) rd_data = mtimecmp_q[h];
      end
    end else if (sel_ctrl) begin
      rd_data = {32'b0, presc_q, 14'b0, halt_en_q, en_q};
    end else if (sel_mtime) begin
      rd_data = mtime_q;
    end
  end

  logic [cpu_total-1:0] msip_we, ssip_we, cmp_we, soft_wd;
  always_comb begin
    msip_we = '0;
    ssip_we = '0;
    cmp_we  = '0;
    soft_wd = '0;
    for (int h = 0; h < cpu_total; h++) begin
      msip_we[h] = wr & sel_msip & (pair_idx == 4'(h >> 1)) & ((h % 2 == 1) ? hi_wr : lo_wr);
      ssip_we[h] = wr & sel_ssip & (pair_idx == 4'(h >> 1)) & ((h % 2 == 1) ? hi_wr : lo_wr);
      cmp_we[h]  = wr & sel_cmp & (cmp_idx == 5'(h));
      soft_wd[h] = (h % 2 == 1) ? wdata[32] : wdata[0];
    end
  end

  // Tick generation: the counter only advances while the timer is not frozen.
  logic        freeze, tick, ctrl_we, presc_we, mtime_we;
  logic [63:0] mtime_tick, mtime_d;

  assign freeze     = ~en_q | (halt_en_q & i_dbg_halt);
  assign tick       = ~freeze & (cnt_q == presc_q);
  assign ctrl_we    = wr & sel_ctrl;
  assign presc_we   = ctrl_we & (|wstrb[3:2]);
  assign mtime_we   = wr & sel_mtime;
  assign mtime_tick = mtime_q + 64'(tick);
  assign mtime_d    = mtime_we ? merge_bytes(mtime_tick, wdata, wstrb) : mtime_tick;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt_q     <= '0;
      mtime_q   <= '0;
      en_q      <= 1'b1;
      halt_en_q <= 1'b1;
      presc_q   <= presc_default;
    end else begin
      if (presc_we || tick) begin
        cnt_q <= '0;
      end else if (!freeze) begin
        cnt_q <= cnt_q + 16'd1;
      end
      mtime_q <= mtime_d;
      if (ctrl_we && wstrb[0]) begin
        en_q      <= wdata[0];
        halt_en_q <= wdata[1];
      end
      if (ctrl_we && wstrb[2]) presc_q[7:0]  <= wdata[23:16];
      if (ctrl_we && wstrb[3]) presc_q[15:8] <= wdata[31:24];
    end
  end

  // Per-hart state; mtip compares against the values held before this edge.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      msip_q <= '0;
      ssip_q <= '0;
      o_mtip <= '0;
      for (int h = 0; h < cpu_total; h++) mtimecmp_q[h] <= mtimecmp_rst;
    end else begin
      for (int h = 0; h < cpu_total; h++) begin
        if (msip_we[h]) msip_q[h] <= soft_wd[h];
        if (ssip_we[h]) ssip_q[h] <= soft_wd[h];
        if (cmp_we[h])  mtimecmp_q[h] <= merge_bytes(mtimecmp_q[h], wdata, wstrb);
        o_mtip[h] <= (mtime_q >= mtimecmp_q[h]);
      end
    end
  end

  // Response stage: one cycle after accept; dropped by reset.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      bus.o_resp_valid <= 1'b0;
      bus.o_resp_rdata <= '0;
      bus.o_resp_err   <= 1'b0;
    end else begin
      bus.o_resp_valid <= bus.i_req_valid;
      if (bus.i_req_valid) begin
        bus.o_resp_rdata <= rd_data;
        bus.o_resp_err   <= map_err;
      end
    end
  end

  assign bus.o_req_ready = 1'b1;
  assign o_mtimer        = mtime_q;
  assign o_msip          = msip_q;
  assign o_ssip          = ssip_q;

endmodule

// File: tb/tb_aclint_timer.sv
// Directed bench for aclint_timer: register-map vector table plus hand-written
// sequences for reset, timer interrupt, prescaler, halt, wrap and tick/write collision.
module tb_aclint_timer;
  logic        clk;
  logic        nrst;
  logic        dbg_halt;
  logic [63:0] mtimer;
  logic [3:0]  msip, mtip, ssip;

  aclint_timer_if bus();

  aclint_timer #(.cpu_total(4)) dut (
    .clk        (clk),
    .nrst       (nrst),
    .bus        (bus),
    .i_dbg_halt (dbg_halt),
    .o_mtimer   (mtimer),
    .o_msip     (msip),
    .o_mtip     (mtip),
    .o_ssip     (ssip)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic xact(input logic [15:0] a, input logic w, input logic [63:0] d,
                      input logic [7:0] s, output logic [63:0] rd, output logic e,
                      output logic v);
    @(negedge clk);
    bus.i_req_valid = 1'b1;
    bus.i_req_addr  = a;
    bus.i_req_write = w;
    bus.i_req_wdata = d;
    bus.i_req_wstrb = s;
    @(posedge clk);
    #1;
    rd = bus.o_resp_rdata;
    e  = bus.o_resp_err;
    v  = bus.o_resp_valid;
    bus.i_req_valid = 1'b0;
    bus.i_req_write = 1'b0;
  endtask

  typedef struct {
    logic [15:0] addr;
    logic        wr;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic [63:0] rdata;
    logic        err;
    logic [3:0]  msip;
    logic [3:0]  ssip;
  } vec_t;

  vec_t tbl[17];

  logic [63:0] rd, m0;
  logic        e, v, found;

  initial begin
    tbl[0]  = '{16'h0000, 1'b0, 64'h0,                   8'h00, 64'h0,                   1'b0, 4'b0000, 4'b0000};
    tbl[1]  = '{16'h0000, 1'b1, 64'h1_0000_0001,         8'hF0, 64'h0,                   1'b0, 4'b0010, 4'b0000};
    tbl[2]  = '{16'h0000, 1'b0, 64'h0,                   8'h00, 64'h1_0000_0000,         1'b0, 4'b0010, 4'b0000};
    tbl[3]  = '{16'hC008, 1'b1, 64'h1,                   8'h0F, 64'h0,                   1'b0, 4'b0010, 4'b0100};
    tbl[4]  = '{16'hC008, 1'b0, 64'h0,                   8'h00, 64'h1,                   1'b0, 4'b0010, 4'b0100};
    tbl[5]  = '{16'h4008, 1'b1, 64'h1122334455667788,    8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 4'b0010, 4'b0100};
    tbl[6]  = '{16'h4008, 1'b1, 64'hAAAAAAAAAAAAAAAA,    8'h81, 64'h1122334455667788,    1'b0, 4'b0010, 4'b0100};
    tbl[7]  = '{16'h4008, 1'b0, 64'h0,                   8'h00, 64'hAA223344556677AA,    1'b0, 4'b0010, 4'b0100};
    tbl[8]  = '{16'h8000, 1'b0, 64'h0,                   8'h00, 64'h0,                   1'b1, 4'b0010, 4'b0100};
    tbl[9]  = '{16'h8000, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 64'h0,                   1'b1, 4'b0010, 4'b0100};
    tbl[10] = '{16'h4020, 1'b0, 64'h0,                   8'h00, 64'h0,                   1'b0, 4'b0010, 4'b0100};
    tbl[11] = '{16'h4020, 1'b1, 64'h0,                   8'hFF, 64'h0,                   1'b0, 4'b0010, 4'b0100};
    tbl[12] = '{16'hBFF0, 1'b0, 64'h0,                   8'h00, 64'h2,                   1'b0, 4'b0010, 4'b0100};
    tbl[13] = '{16'h0008, 1'b1, 64'h1_0000_0001,         8'hFF, 64'h0,                   1'b0, 4'b1110, 4'b0100};
    tbl[14] = '{16'h0008, 1'b0, 64'h0,                   8'h00, 64'h1_0000_0001,         1'b0, 4'b1110, 4'b0100};
    tbl[15] = '{16'h0010, 1'b1, 64'h1_0000_0001,         8'hFF, 64'h0,                   1'b0, 4'b1110, 4'b0100};
    tbl[16] = '{16'hC000, 1'b0, 64'h0,                   8'h00, 64'h0,                   1'b0, 4'b1110, 4'b0100};

    bus.i_req_valid = 1'b0;
    bus.i_req_addr  = '0;
    bus.i_req_write = 1'b0;
    bus.i_req_wdata = '0;
    bus.i_req_wstrb = '0;
    dbg_halt = 1'b0;
    nrst     = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_resp_valid", 64'(bus.o_resp_valid), 64'h0);
    chk("rst_req_ready",  64'(bus.o_req_ready),  64'h1);
    chk("rst_mtimer",     mtimer,                64'h0);
    chk("rst_msip",       64'(msip),             64'h0);
    chk("rst_mtip",       64'(mtip),             64'h0);
    @(negedge clk);
    nrst = 1'b1;

    // mtimecmp[0]=0 raises mtip[0] so the following reset has something to clear
    repeat (5) @(posedge clk);
    xact(16'h4000, 1'b1, 64'h0, 8'hFF, rd, e, v);
    @(posedge clk);
    #1;
    chk("mtip0_set", 64'(mtip), 64'h1);

    // Reset asserted while a read is in flight
    @(negedge clk);
    bus.i_req_valid = 1'b1;
    bus.i_req_addr  = 16'h4000;
    bus.i_req_write = 1'b0;
    #2 nrst = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_mid_resp_valid", 64'(bus.o_resp_valid), 64'h0);
    chk("rst_mid_mtip",       64'(mtip),             64'h0);
    chk("rst_mid_mtimer",     mtimer,                64'h0);
    @(negedge clk);
    bus.i_req_valid = 1'b0;
    nrst = 1'b1;
    xact(16'h4000, 1'b0, 64'h0, 8'h00, rd, e, v);
    chk("post_rst_cmp0", rd, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("post_rst_valid", 64'(v), 64'h1);
    xact(16'hBFF0, 1'b0, 64'h0, 8'h00, rd, e, v);
    chk("post_rst_ctrl", rd, 64'h3);

    // Register map table with the timer disabled
    xact(16'hBFF0, 1'b1, 64'h2, 8'hFF, rd, e, v);
    for (int i = 0; i < 17; i++) begin
      xact(tbl[i].addr, tbl[i].wr, tbl[i].wdata, tbl[i].wstrb, rd, e, v);
      chk($sformatf("vec%0d_valid", i), 64'(v),       64'h1);
      chk($sformatf("vec%0d_rdata", i), rd,           tbl[i].rdata);
      chk($sformatf("vec%0d_err",   i), 64'(e),       64'(tbl[i].err));
      chk($sformatf("vec%0d_msip",  i), 64'(msip),    64'(tbl[i].msip));
      chk($sformatf("vec%0d_ssip",  i), 64'(ssip),    64'(tbl[i].ssip));
    end
    @(posedge clk);
    #1;
    chk("resp_valid_drop", 64'(bus.o_resp_valid), 64'h0);

    // Timer interrupt on hart 2
    xact(16'h4010, 1'b1, 64'd100, 8'hFF, rd, e, v);
    xact(16'hBFF8, 1'b1, 64'd90,  8'hFF, rd, e, v);
    chk("mtime_written", mtimer, 64'd90);
    xact(16'hBFF0, 1'b1, 64'h3,   8'hFF, rd, e, v);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(posedge clk);
      #1;
      if (mtimer == 64'd100) found = 1'b1;
    end
    chk("mtime_reach_100", 64'(found), 64'h1);
    chk("mtip_at_100", 64'(mtip), 64'h0);
    @(posedge clk);
    #1;
    chk("mtip_rise", 64'(mtip), 64'h4);
    xact(16'h4010, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, rd, e, v);
    chk("mtip_hold", 64'(mtip), 64'h4);
    @(posedge clk);
    #1;
    chk("mtip_fall", 64'(mtip), 64'h0);

    // Debug halt freezes mtime while halt_en=1
    @(negedge clk);
    dbg_halt = 1'b1;
    @(posedge clk);
    #1;
    m0 = mtimer;
    repeat (20) @(posedge clk);
    #1;
    chk("halt_frozen", mtimer, m0);
    @(negedge clk);
    dbg_halt = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("halt_resume", mtimer, m0 + 64'd5);

    // halt_en=0: debug halt is ignored
    xact(16'hBFF0, 1'b1, 64'h1, 8'hFF, rd, e, v);
    @(negedge clk);
    dbg_halt = 1'b1;
    @(posedge clk);
    #1;
    m0 = mtimer;
    repeat (5) @(posedge clk);
    #1;
    chk("halt_ignored", mtimer, m0 + 64'd5);
    @(negedge clk);
    dbg_halt = 1'b0;

    // Prescaler: tick every 4 clocks
    xact(16'hBFF0, 1'b1, 64'h0003_0003, 8'hFF, rd, e, v);
    m0 = mtimer;
    repeat (40) @(posedge clk);
    #1;
    chk("presc_rate", 64'(((mtimer - m0) >= 64'd9) && ((mtimer - m0) <= 64'd11)), 64'h1);
    xact(16'hBFF0, 1'b0, 64'h0, 8'h00, rd, e, v);
    chk("presc_ctrl_read", rd, 64'h0003_0003);

    // Wrap from 2^64-2 through 2^64-1 to 0
    xact(16'hBFF0, 1'b1, 64'h3, 8'hFF, rd, e, v);
    xact(16'hBFF8, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF, rd, e, v);
    chk("wrap_load", mtimer, 64'hFFFF_FFFF_FFFF_FFFE);
    @(posedge clk);
    #1;
    chk("wrap_max", mtimer, 64'hFFFF_FFFF_FFFF_FFFF);
    @(posedge clk);
    #1;
    chk("wrap_zero", mtimer, 64'h0);

    // Low-half write in a tick cycle: upper half carries the ticked value
    xact(16'hBFF8, 1'b1, 64'h0000_0005_FFFF_FFFF, 8'hFF, rd, e, v);
    chk("tickwr_load", mtimer, 64'h0000_0005_FFFF_FFFF);
    xact(16'hBFF8, 1'b1, 64'hDEAD_BEEF_1234_5678, 8'h0F, rd, e, v);
    chk("tickwr_old_rdata", rd, 64'h0000_0005_FFFF_FFFF);
    chk("tickwr_merge", mtimer, 64'h0000_0006_1234_5678);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
